// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the seq_detect pattern checker.
// State encoding, default pattern and the width helper for the fill counter.
package seq_detect_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] SEQ_PAT_DEFAULT = 4'b1011;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/seq_detect_if.sv
// Serial-bit input and match/status outputs of seq_detect bundled as one port.
// The master side drives the bit stream and clr; the slave side is the detector.
interface seq_detect_if #(
  parameter int CNT_W = 8
);

  logic             clr;
  logic             din_valid;
  logic             din;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             armed;

  modport master (
    output clr, din_valid, din,
    input  match, match_count, armed
  );

  modport slave (
    input  clr, din_valid, din,
    output match, match_count, armed
  );

endinterface

// File: rtl/seq_shift_hist.sv
// PAT_LEN-bit history shift register for seq_detect, newest bit in the LSB.
// cand is the window the incoming bit would create, used for same-cycle compare.
module seq_shift_hist #(
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               din,
  output logic [PAT_LEN-1:0] hist,
  output logic [PAT_LEN-1:0] cand
);

  // clr wins over a same-cycle shift so a discarded bit never enters history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {hist[PAT_LEN-2:0], din};
    end
  end

  assign cand = {hist[PAT_LEN-2:0], din};

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: registered match pulse, saturating match count, armed flag.
// Define SEQ_DETECT_NONOVERLAP_EN to restart history after each hit (no bit reuse).
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(SEQ_PAT_DEFAULT),
  parameter int                 CNT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  seq_detect_if.slave  bus
);

  localparam int               FILL_W    = clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

  state_t             state;
  state_t             next_state;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] cand;
  logic               hit;
  logic               hist_clr;
  logic               match_q;
  logic               match_d;
  logic               armed_q;
  logic               armed_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  // While filling, only the bit that completes PAT_LEN may produce a hit
  assign hit = bus.din_valid && (cand == PATTERN) &&
               ((state == ST_RUN) || (fill == FILL_LAST));

`ifdef SEQ_DETECT_NONOVERLAP_EN
  assign hist_clr = bus.clr | hit;
`else
  assign hist_clr = bus.clr;
`endif

  seq_shift_hist #(
    .PAT_LEN (PAT_LEN)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (hist_clr),
    .shift_en (bus.din_valid),
    .din      (bus.din),
    .hist     (),
    .cand     (cand)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
    end else if (bus.clr) begin
      state <= ST_FILL;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FILL: if (bus.din_valid && (fill == FILL_LAST)) next_state = ST_RUN;
      ST_RUN:  next_state = ST_RUN;
    endcase
`ifdef SEQ_DETECT_NONOVERLAP_EN
    if (hit) next_state = ST_FILL;
`endif
  end

  // fill parks at PAT_LEN once running; it only matters in FILL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (bus.clr) begin
      fill <= '0;
`ifdef SEQ_DETECT_NONOVERLAP_EN
    end else if (hit) begin
      fill <= '0;
`endif
    end else if ((state == ST_FILL) && bus.din_valid) begin
      fill <= fill + FILL_W'(1);
    end
  end

  always_comb begin
    match_d = hit;
    armed_d = (next_state == ST_RUN);
    count_d = count_q;
    if (hit && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
      armed_q <= 1'b0;
      count_q <= '0;
    end else if (bus.clr) begin
      match_q <= 1'b0;
      armed_q <= 1'b0;
      count_q <= '0;
    end else begin
      match_q <= match_d;
      armed_q <= armed_d;
      count_q <= count_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.armed       = armed_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect.sv
// Scoreboard bench for seq_detect: an 8-bit-count and a 2-bit-count instance share one stimulus.
// Expected pulses are queued with their cycle and count; a monitor pops them as match appears.
module tb_seq_detect;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cycleCnt = 0;
  int   expCntA = 0;
  int   expCntB = 0;
  exp_t qA[$];
  exp_t qB[$];

  seq_detect_if #(.CNT_W(8)) busA ();
  seq_detect_if #(.CNT_W(2)) busB ();

  seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue any expected pulse
  task automatic applyStimulus(input logic c, input logic v, input logic d, input bit expHit);
    @(negedge clk);
    busA.clr = c; busA.din_valid = v; busA.din = d;
    busB.clr = c; busB.din_valid = v; busB.din = d;
    if (c) begin
      expCntA = 0;
      expCntB = 0;
    end else if (expHit) begin
      if (expCntA < 255) expCntA++;
      if (expCntB < 3) expCntB++;
      qA.push_back('{cyc: cycleCnt + 1, cnt: expCntA});
      qB.push_back('{cyc: cycleCnt + 1, cnt: expCntB});
    end
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n, input logic [15:0] hits);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, bits[n-1-i], hits[n-1-i]);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, cycleCnt[0], 1'b0);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    cycleCnt++;
    #1;
    if (qA.size() > 0 && qA[0].cyc < cycleCnt) begin
      e = qA.pop_front();
      checkOutput("missing_match_a_cycle", cycleCnt, e.cyc);
    end
    if (qB.size() > 0 && qB[0].cyc < cycleCnt) begin
      e = qB.pop_front();
      checkOutput("missing_match_b_cycle", cycleCnt, e.cyc);
    end
    if (busA.match !== 1'b0) begin
      if (qA.size() == 0) begin
        checkOutput("spurious_match_a", 1, 0);
      end else begin
        e = qA.pop_front();
        checkOutput("match_cycle_a", cycleCnt, e.cyc);
        checkOutput("match_count_a", int'(busA.match_count), e.cnt);
      end
    end
    if (busB.match !== 1'b0) begin
      if (qB.size() == 0) begin
        checkOutput("spurious_match_b", 1, 0);
      end else begin
        e = qB.pop_front();
        checkOutput("match_cycle_b", cycleCnt, e.cyc);
        checkOutput("match_count_b", int'(busB.match_count), e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    busA.clr = 1'b0; busA.din_valid = 1'b0; busA.din = 1'b0;
    busB.clr = 1'b0; busB.din_valid = 1'b0; busB.din = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_match", int'(busA.match), 0);
    checkOutput("reset_count", int'(busA.match_count), 0);
    checkOutput("reset_armed", int'(busA.armed), 0);
    rst = 1'b0;

    $display("[TB] basic 1011");
    sendBits(16'b101, 3, 16'b000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("basic_armed_3bits", int'(busA.armed), 0);
    idle();
    checkOutput("basic_armed_4bits", int'(busA.armed), 1);
    checkOutput("basic_count", int'(busA.match_count), 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    checkOutput("clr_count", int'(busA.match_count), 0);
    checkOutput("clr_armed", int'(busA.armed), 0);

    $display("[TB] overlap 1011011");
`ifdef SEQ_DETECT_NONOVERLAP_EN
    sendBits(16'b1011011, 7, 16'b0001000);
    idle();
    checkOutput("overlap_count", int'(busA.match_count), 1);
`else
    sendBits(16'b1011011, 7, 16'b0001001);
    idle();
    checkOutput("overlap_count", int'(busA.match_count), 2);
`endif

    $display("[TB] valid gaps");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("gaps_count", int'(busA.match_count), 1);

    $display("[TB] async reset mid-stream");
    sendBits(16'b101, 3, 16'b000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expCntA = 0;
    expCntB = 0;
    #1;
    checkOutput("async_rst_match", int'(busA.match), 0);
    checkOutput("async_rst_count", int'(busA.match_count), 0);
    checkOutput("async_rst_armed", int'(busA.armed), 0);
    idle();
    rst = 1'b0;
    sendBits(16'b111011, 6, 16'b000001);
    idle();
    checkOutput("post_rst_count", int'(busA.match_count), 1);
    checkOutput("post_rst_armed", int'(busA.armed), 1);

    $display("[TB] saturation");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      sendBits(16'b1011, 4, 16'b0001);
      idle();
    end
    checkOutput("sat_count_a", int'(busA.match_count), 5);
    checkOutput("sat_count_b", int'(busB.match_count), 3);

    $display("[TB] clr priority");
    sendBits(16'b101, 3, 16'b000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    checkOutput("clrpri_match", int'(busA.match), 0);
    checkOutput("clrpri_count_a", int'(busA.match_count), 0);
    checkOutput("clrpri_count_b", int'(busB.match_count), 0);
    checkOutput("clrpri_armed", int'(busA.armed), 0);

    repeat (3) idle();
    checkOutput("pending_a", qA.size(), 0);
    checkOutput("pending_b", qB.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect.md
Name: seq_detect

Overview:
- Downstream consumer of the single-bit flip-flop output stream.
- Samples a serial bit stream qualified by a valid strobe and detects a parameterised bit pattern.
- Emits a registered one-cycle match pulse and keeps a saturating match count.
- Sits after the D flip-flop stage in the serial datapath; used as a pattern/sequence checker on lab boards.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, target pattern, MSB = oldest bit, width PAT_LEN.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of history, count and match.
- din_valid  input  1  din is sampled this cycle when high.
- din  input  1  serial data bit (the upstream flip-flop q).
- match  output  1  one-cycle pulse, registered.
- match_count  output  CNT_W  saturating number of matches since reset/clr.
- armed  output  1  high once PAT_LEN valid bits are held in history.

Behaviour:
- Reset (rst=1, asynchronous): history=0, fill=0, state=FILL, match=0, match_count=0, armed=0. Outputs are forced immediately, not at the next edge.
- History: hist[PAT_LEN-1:0]. On each accepted bit (din_valid=1), hist <= {hist[PAT_LEN-2:0], din}. With din_valid=0, nothing changes except match, which drops to 0.
- Compare window: cand = {hist[PAT_LEN-2:0], din}.
- Hit condition: din_valid=1, cand==PATTERN, and (state==RUN, or state==FILL with fill==PAT_LEN-1).
- Latency: match is high in the cycle after the accepting edge, for exactly one cycle. Consecutive hits give back-to-back pulses.
- FSM states:
  - FILL: count accepted bits in fill (width clog2(PAT_LEN+1)). When fill reaches PAT_LEN, go to RUN.
  - RUN: steady state, armed=1.
- armed = (state==RUN), registered.
- match_count increments by 1 on each hit, registered with match. At all-ones it saturates and holds; no wrap.
- Overlapping detection is the default: history is kept after a hit (1011011 gives 2 hits).
- clr=1: same values as reset, applied at the clock edge. clr has priority over a same-cycle valid bit, which is discarded.
- rst asserted mid-stream: partial history is lost; after release a full PAT_LEN bits are needed before any hit.
- din is unknown while din_valid=0: no effect.

Optional Feature:
- Macro: SEQ_DETECT_NONOVERLAP_EN.
- Defined:
  - After a hit, hist is cleared, fill is cleared and state returns to FILL (armed drops the next cycle).
  - Bits of a found pattern are never reused.
- Undefined: overlapping detection as above.
- Reset, latency and saturation rules are identical in both modes.

Decomposition:
- Package seq_detect_pkg:
  - state encoding localparams ST_FILL=1'b0, ST_RUN=1'b1.
  - default pattern constant SEQ_PAT_DEFAULT=4'b1011.
  - clog2 function for the fill width.
- One sub-module, seq_shift_hist:
  - Parameterised PAT_LEN shift register with valid-enable, sync clear and async reset.
  - Outputs hist and the candidate window.
- FSM, compare and counter live in the top.

Test Plan (PAT_LEN=4, PATTERN=1011, CNT_W=8 unless noted):
- Basic: valid each cycle, din 1,0,1,1 -> match=1 one cycle after the 4th bit, count=1, armed=1 after 4 bits.
- Overlap: din 1,0,1,1,0,1,1 -> hits on bits 4 and 7, count=2. With SEQ_DETECT_NONOVERLAP_EN -> hit on bit 4 only, count=1.
- Valid gaps: 1,0,1,1 with din_valid=0 (din toggling) between each bit -> a single match after the 4th valid bit, no spurious pulses.
- Async reset: rst pulse mid-cycle after bits 1,0,1 -> outputs 0 at once. Then 1,1 -> no match. Then full 1,0,1,1 -> match, count=1.
- Saturation (CNT_W=2): five separated 1011 patterns -> count 1,2,3,3,3; match still pulses each time.
- clr priority: clr=1 with din_valid=1 on the 4th bit of 1011 -> no match, count=0, armed=0.
